// File: rtl/fft8_axil_slave.sv
// fft8_axil_slave: AXI4-Lite register front end for an 8-point complex FFT core.
// Holds the eight input samples (X), captures the eight results (Y), and runs a
// two-state start/done handshake with the core.
// Optional feature macro: FFT8_IRQ_EN adds the irq output and the CTRL.IRQ_EN bit.
module fft8_axil_slave #(
   parameter int unsigned C_ADDR_WIDTH = 7
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [C_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic                    S_AXI_AWVALID,
   output logic                    S_AXI_AWREADY,
   input  logic [31:0]             S_AXI_WDATA,
   input  logic [3:0]              S_AXI_WSTRB,
   input  logic                    S_AXI_WVALID,
   output logic                    S_AXI_WREADY,
   output logic [1:0]              S_AXI_BRESP,
   output logic                    S_AXI_BVALID,
   input  logic                    S_AXI_BREADY,
   input  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic                    S_AXI_ARVALID,
   output logic                    S_AXI_ARREADY,
   output logic [31:0]             S_AXI_RDATA,
   output logic [1:0]              S_AXI_RRESP,
   output logic                    S_AXI_RVALID,
   input  logic                    S_AXI_RREADY,
   output logic                    core_start,
   output logic [255:0]            core_x,
   input  logic                    core_done,
   input  logic [255:0]            core_y
`ifdef FFT8_IRQ_EN
   ,
   output logic                    irq
`endif
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {ST_IDLE, ST_RUN} state_e;
   typedef enum logic [2:0] {R_CTRL, R_STATUS, R_X, R_Y, R_NONE} region_e;

   // Unaligned addresses and anything outside 0x00-0x5C fall into R_NONE.
   function automatic region_e decode(input logic [C_ADDR_WIDTH-1:0] a);
      logic [4:0] w;
      w = a[6:2];
      if (((a >> 7) != '0) || (a[1:0] != 2'b00)) return R_NONE;
      if (w == 5'd0) return R_CTRL;
      if (w == 5'd1) return R_STATUS;
      if (w[4:3] == 2'b01) return R_X;
      if (w[4:3] == 2'b10) return R_Y;
      return R_NONE;
   endfunction

   state_e            state_q, state_d;
   logic [7:0][31:0]  x_q, x_d;
   logic [7:0][31:0]  y_q, y_d;
   logic              done_q, done_d;
   logic              core_start_q, core_start_d;
   logic              awready_q, awready_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              arready_q, arready_d;
   logic              rvalid_q, rvalid_d;
   logic [1:0]        rresp_q, rresp_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              wr_fire, ar_fire, start_req, clr_done, busy, irq_en_rd;
   region_e           wr_region, rd_region;
   logic [2:0]        wr_idx, rd_idx;
`ifdef FFT8_IRQ_EN
   logic              irq_en_q, irq_en_d;
   logic              irq_q, irq_d;
   assign irq_en_rd = irq_en_q;
   assign irq       = irq_q;
`else
   assign irq_en_rd = 1'b0;
`endif

   assign busy          = (state_q == ST_RUN);
   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;
   assign core_start    = core_start_q;
   assign core_x        = x_q;

   // FSM state register.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: START launches the core, core_done returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_req) state_d = ST_RUN;
         ST_RUN:  if (core_done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Register file, AXI handshakes and read mux.
   always_comb begin
      x_d          = x_q;
      y_d          = y_q;
      done_d       = done_q;
      bvalid_d     = bvalid_q;
      bresp_d      = bresp_q;
      rvalid_d     = rvalid_q;
      rresp_d      = rresp_q;
      rdata_d      = rdata_q;
      start_req    = 1'b0;
      clr_done     = 1'b0;
`ifdef FFT8_IRQ_EN
      irq_en_d     = irq_en_q;
`endif
      // Ready is a one-cycle pulse; the following edge is the handshake.
      awready_d    = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
      arready_d    = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
      wr_fire      = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
      ar_fire      = arready_q & S_AXI_ARVALID;
      wr_region    = decode(S_AXI_AWADDR);
      rd_region    = decode(S_AXI_ARADDR);
      wr_idx       = S_AXI_AWADDR[4:2];
      rd_idx       = S_AXI_ARADDR[4:2];

      if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
      if (wr_fire) begin
         bvalid_d = 1'b1;
         bresp_d  = RESP_OKAY;
         case (wr_region)
            R_CTRL: if (S_AXI_WSTRB[0]) begin
               start_req = S_AXI_WDATA[0] & ~busy;
`ifdef FFT8_IRQ_EN
               irq_en_d  = S_AXI_WDATA[1];
`endif
            end
            R_STATUS: if (S_AXI_WSTRB[0]) clr_done = S_AXI_WDATA[1];
            R_X: begin
               if (busy) bresp_d = RESP_SLVERR;
               else begin
                  for (int unsigned b = 0; b < 4; b++)
                     if (S_AXI_WSTRB[b]) x_d[wr_idx][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
               end
            end
            default: bresp_d = RESP_SLVERR;
         endcase
      end

      // A result capture overrides a simultaneous DONE clear.
      if (clr_done) done_d = 1'b0;
      if (busy && core_done) begin
         y_d    = core_y;
         done_d = 1'b1;
      end

      if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
      if (ar_fire) begin
         rvalid_d = 1'b1;
         rresp_d  = RESP_OKAY;
         case (rd_region)
            R_CTRL:   rdata_d = {30'd0, irq_en_rd, 1'b0};
            R_STATUS: rdata_d = {30'd0, done_q, busy};
            R_X:      rdata_d = x_q[rd_idx];
            R_Y:      rdata_d = y_q[rd_idx];
            default: begin
               rdata_d = '0;
               rresp_d = RESP_SLVERR;
            end
         endcase
      end
      core_start_d = start_req;
`ifdef FFT8_IRQ_EN
      irq_d        = done_q & irq_en_q;
`endif
   end

   // Datapath and handshake registers.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         x_q          <= '0;
         y_q          <= '0;
         done_q       <= 1'b0;
         core_start_q <= 1'b0;
         awready_q    <= 1'b0;
         bvalid_q     <= 1'b0;
         bresp_q      <= '0;
         arready_q    <= 1'b0;
         rvalid_q     <= 1'b0;
         rresp_q      <= '0;
         rdata_q      <= '0;
`ifdef FFT8_IRQ_EN
         irq_en_q     <= 1'b0;
         irq_q        <= 1'b0;
`endif
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         done_q       <= done_d;
         core_start_q <= core_start_d;
         awready_q    <= awready_d;
         bvalid_q     <= bvalid_d;
         bresp_q      <= bresp_d;
         arready_q    <= arready_d;
         rvalid_q     <= rvalid_d;
         rresp_q      <= rresp_d;
         rdata_q      <= rdata_d;
`ifdef FFT8_IRQ_EN
         irq_en_q     <= irq_en_d;
         irq_q        <= irq_d;
`endif
      end
   end

endmodule
